// File: rtl/loader_pkg.sv
// Shared types and constants for the boot loader: state encoding, header field
// positions and error codes. LOADER_VERIFY_EN adds the read-back CHECK state.
package loader_pkg;

`ifdef LOADER_VERIFY_EN
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_DATA, S_CHECK, S_RUN, S_ERROR} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_DATA, S_RUN, S_ERROR} state_e;
`endif

    localparam int TGT_BIT   = 31;
    localparam int RSVD_MSB  = 30;
    localparam int RSVD_LSB  = 26;
    localparam int START_MSB = 25;
    localparam int START_LSB = 16;
    localparam int CNT_MSB   = 15;
    localparam int CNT_LSB   = 0;

    localparam logic [1:0] ERR_RSVD   = 2'd1;
    localparam logic [1:0] ERR_RANGE  = 2'd2;
    localparam logic [1:0] ERR_VERIFY = 2'd3;

endpackage

// File: rtl/loader_mem_port.sv
// Registered ext-port driver: a write request shows up on wen/addr/wdata one cycle
// later; addr/wdata hold between writes. LOADER_VERIFY_EN enables the ren path.
module loader_mem_port (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wen,
    output logic        ren,
    output logic [31:0] addr,
    output logic [31:0] wdata
);
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    // Reads reuse the held address of the last write, which is the word being verified.
    always_comb begin
        wen_d   = wr_req;
        addr_d  = wr_req ? wr_addr : addr_q;
        wdata_d = wr_req ? wr_data : wdata_q;
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef LOADER_VERIFY_EN
    logic ren_q;
    always_ff @(posedge clk) begin
        if (!arst_n) ren_q <= 1'b0;
        else         ren_q <= rd_req;
    end
    assign ren = ren_q;
`else
    logic unused_rd_req;
    assign unused_rd_req = rd_req;
    assign ren           = 1'b0;
`endif

    assign wen   = wen_q;
    assign addr  = addr_q;
    assign wdata = wdata_q;

endmodule

// File: rtl/cpu_boot_loader.sv
// Streams segment headers + payload into imem/dmem, then enables the core.
// Optional read-back verification of every write under LOADER_VERIFY_EN.
module cpu_boot_loader
    import loader_pkg::*;
#(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024,
    parameter int ADDR_STEP  = 4,
    parameter int RD_LAT     = 1
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic [31:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic [31:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [31:0] wdata_ext_2,
    input  logic [31:0] rdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        tgt_q, tgt_d;
    logic [1:0]  err_q, err_d;
    logic        in_ready_q, busy_q, done_q, error_q, cpu_enable_q;
    logic        accept, imem_wr, dmem_wr, imem_rd, dmem_rd;
    logic [9:0]  hdr_start;
    logic [15:0] hdr_cnt;
    logic [16:0] hdr_end, hdr_depth;

    assign accept    = in_valid & in_ready_q;
    assign hdr_start = in_data[START_MSB:START_LSB];
    assign hdr_cnt   = in_data[CNT_MSB:CNT_LSB];
    assign hdr_end   = {7'd0, hdr_start} + {1'b0, hdr_cnt};
    assign hdr_depth = in_data[TGT_BIT] ? 17'(DMEM_WORDS) : 17'(IMEM_WORDS);

`ifdef LOADER_VERIFY_EN
    logic [7:0]  chk_q, chk_d;
    logic [31:0] wword_q, wword_d;
    logic [31:0] rd_word;
    assign rd_word = tgt_q ? rdata_ext_2 : rdata_ext;
`else
    logic unused_rdata;
    assign unused_rdata = (^{rdata_ext, rdata_ext_2}) ^ (RD_LAT != 0);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        tgt_d   = tgt_q;
        err_d   = err_q;
        imem_wr = 1'b0;
        dmem_wr = 1'b0;
        imem_rd = 1'b0;
        dmem_rd = 1'b0;
`ifdef LOADER_VERIFY_EN
        chk_d   = chk_q;
        wword_d = wword_q;
`endif
        case (state_q)
            S_IDLE: if (start) state_d = S_HEADER;
            S_HEADER: if (accept) begin
                if (hdr_cnt == 16'd0) begin
                    state_d = S_RUN;
                end else if (in_data[RSVD_MSB:RSVD_LSB] != 5'd0) begin
                    state_d = S_ERROR;
                    err_d   = ERR_RSVD;
                end else if (hdr_end > hdr_depth) begin
                    state_d = S_ERROR;
                    err_d   = ERR_RANGE;
                end else begin
                    tgt_d   = in_data[TGT_BIT];
                    addr_d  = 32'(hdr_start) * 32'(ADDR_STEP);
                    cnt_d   = hdr_cnt;
                    state_d = S_DATA;
                end
            end
            S_DATA: if (accept) begin
                imem_wr = ~tgt_q;
                dmem_wr = tgt_q;
                addr_d  = addr_q + 32'(ADDR_STEP);
                cnt_d   = cnt_q - 16'd1;
`ifdef LOADER_VERIFY_EN
                chk_d   = 8'd0;
                wword_d = in_data;
                state_d = S_CHECK;
`else
                if (cnt_q == 16'd1) state_d = S_HEADER;
`endif
            end
`ifdef LOADER_VERIFY_EN
            // chk 0: write is on the port, request the read; rdata lands RD_LAT after ren.
            S_CHECK: begin
                chk_d = chk_q + 8'd1;
                if (chk_q == 8'd0) begin
                    imem_rd = ~tgt_q;
                    dmem_rd = tgt_q;
                end
                if (chk_q == 8'(RD_LAT + 1)) begin
                    if (rd_word != wword_q) begin
                        state_d = S_ERROR;
                        err_d   = ERR_VERIFY;
                    end else begin
                        state_d = (cnt_q == 16'd0) ? S_HEADER : S_DATA;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            tgt_q        <= 1'b0;
            err_q        <= 2'd0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_enable_q <= 1'b0;
`ifdef LOADER_VERIFY_EN
            chk_q        <= '0;
            wword_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            tgt_q        <= tgt_d;
            err_q        <= err_d;
            in_ready_q   <= (state_d == S_HEADER) || (state_d == S_DATA);
`ifdef LOADER_VERIFY_EN
            busy_q       <= (state_d == S_HEADER) || (state_d == S_DATA) || (state_d == S_CHECK);
            chk_q        <= chk_d;
            wword_q      <= wword_d;
`else
            busy_q       <= (state_d == S_HEADER) || (state_d == S_DATA);
`endif
            done_q       <= (state_d == S_RUN);
            cpu_enable_q <= (state_d == S_RUN);
            error_q      <= (state_d == S_ERROR);
        end
    end

    loader_mem_port u_imem_port (
        .clk     (clk),
        .arst_n  (arst_n),
        .wr_req  (imem_wr),
        .rd_req  (imem_rd),
        .wr_addr (addr_q),
        .wr_data (in_data),
        .wen     (wen_ext),
        .ren     (ren_ext),
        .addr    (addr_ext),
        .wdata   (wdata_ext)
    );

    loader_mem_port u_dmem_port (
        .clk     (clk),
        .arst_n  (arst_n),
        .wr_req  (dmem_wr),
        .rd_req  (dmem_rd),
        .wr_addr (addr_q),
        .wr_data (in_data),
        .wen     (wen_ext_2),
        .ren     (ren_ext_2),
        .addr    (addr_ext_2),
        .wdata   (wdata_ext_2)
    );

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign cpu_enable = cpu_enable_q;
    assign err_code   = err_q;

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Random and directed images checked against a segment-level model of the loader:
// expected writes, final run/error status and enable timing.
module tb_cpu_boot_loader;
    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0] rdata_ext = '0;
    logic [31:0] rdata_ext_2 = '0;
    logic        cpu_enable, busy, done, error;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    cpu_boot_loader dut (
        .clk (clk), .arst_n (arst_n), .start (start),
        .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
        .addr_ext (addr_ext), .wen_ext (wen_ext), .ren_ext (ren_ext),
        .wdata_ext (wdata_ext), .rdata_ext (rdata_ext),
        .addr_ext_2 (addr_ext_2), .wen_ext_2 (wen_ext_2), .ren_ext_2 (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2), .rdata_ext_2 (rdata_ext_2),
        .cpu_enable (cpu_enable), .busy (busy), .done (done),
        .error (error), .err_code (err_code)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Memory models backing the ext ports (1-cycle registered read).
    logic [31:0] mem_i [0:511];
    logic [31:0] mem_d [0:1023];
    logic        corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = '0;

    always @(posedge clk) begin
        if (wen_ext)   mem_i[addr_ext[10:2]]   <= wdata_ext;
        if (wen_ext_2) mem_d[addr_ext_2[11:2]] <= wdata_ext_2;
        rdata_ext   <= mem_i[addr_ext[10:2]] ^
                       ((ren_ext && corrupt_en && addr_ext == corrupt_addr) ? 32'h1 : 32'h0);
        rdata_ext_2 <= mem_d[addr_ext_2[11:2]];
    end

    // Observed writes; only this block appends.
    bit          obs_port[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    always @(negedge clk) begin
        if (wen_ext)   begin obs_port.push_back(1'b0); obs_addr.push_back(addr_ext);   obs_data.push_back(wdata_ext);   end
        if (wen_ext_2) begin obs_port.push_back(1'b1); obs_addr.push_back(addr_ext_2); obs_data.push_back(wdata_ext_2); end
    end

    // Reference model: walks the image segment by segment.
    logic [31:0] img[$];
    bit          exp_port[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_run;
    logic [1:0]  exp_code;
    int          exp_len;

    task automatic model_image();
        int i;
        bit fin;
        logic [31:0] h;
        int n, s, depth;
        i = 0; fin = 0; exp_run = 0; exp_code = 0;
        exp_port.delete(); exp_addr.delete(); exp_data.delete();
        while (!fin && i < img.size()) begin
            h = img[i]; i++;
            n = int'(h[15:0]); s = int'(h[25:16]); depth = h[31] ? 1024 : 512;
            if (n == 0) begin exp_run = 1; fin = 1; end
            else if (h[30:26] != 5'd0) begin exp_code = 2'd1; fin = 1; end
            else if (s + n > depth) begin exp_code = 2'd2; fin = 1; end
            else begin
                for (int k = 0; k < n; k++) begin
                    exp_port.push_back(h[31]);
                    exp_addr.push_back(32'((s + k) * 4));
                    exp_data.push_back(img[i]);
                    i++;
                end
            end
        end
        exp_len = i;
    endtask

    task automatic do_reset(input bit check_state);
        @(negedge clk); arst_n = 1'b0; in_valid = 1'b0; start = 1'b0; corrupt_en = 1'b0;
        repeat (2) @(negedge clk);
        if (check_state) begin
            check("rst_cpu_enable", cpu_enable, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_error", error, 0);
            check("rst_err_code", err_code, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_wen", {wen_ext, wen_ext_2, ren_ext, ren_ext_2}, 0);
            check("rst_addr", addr_ext | addr_ext_2, 0);
        end
        arst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1; in_data = w; n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("in_ready_wait", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; in_data = $urandom;
    endtask

    task automatic compare_writes(input string tag, input int base);
        int seen;
        seen = obs_port.size() - base;
        check({tag, "_write_count"}, seen, exp_port.size());
        for (int k = 0; k < exp_port.size() && k < seen; k++) begin
            check({tag, "_wr_port"}, obs_port[base + k], exp_port[k]);
            check({tag, "_wr_addr"}, obs_addr[base + k], exp_addr[k]);
            check({tag, "_wr_data"}, obs_data[base + k], exp_data[k]);
        end
    endtask

    // gap < 0 selects a random 0..2 idle cycles before each word.
    task automatic run_image(input string tag, input int gap);
        int base;
        model_image();
        base = obs_port.size();
        do_start();
        for (int i = 0; i < exp_len; i++)
            send_word(img[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
        check({tag, "_enable_next_cycle"}, cpu_enable, exp_run);
        repeat (3) @(negedge clk);
        check({tag, "_done"}, done, exp_run);
        check({tag, "_error"}, error, !exp_run);
        check({tag, "_err_code"}, err_code, exp_code);
        check({tag, "_in_ready_off"}, in_ready, 0);
        check({tag, "_busy_off"}, busy, 0);
        compare_writes(tag, base);
        $display("%s: %0d words sent, %0d writes, run=%0d err_code=%0d",
                 tag, exp_len, exp_port.size(), exp_run, exp_code);
    endtask

    task automatic build_happy();
        img.delete();
        img.push_back(32'h0000_0003);
        repeat (3) img.push_back($urandom);
        img.push_back(32'h8002_0001);
        img.push_back($urandom);
        img.push_back(32'h0000_0000);
    endtask

    task automatic build_random();
        int nseg, n, s, depth;
        bit tgt;
        int kind;
        img.delete();
        nseg = $urandom_range(1, 3);
        for (int g = 0; g < nseg; g++) begin
            tgt = 1'($urandom_range(0, 1)); n = $urandom_range(1, 5);
            depth = tgt ? 1024 : 512;
            s = $urandom_range(0, depth - n);
            img.push_back({tgt, 5'd0, 10'(s), 16'(n)});
            for (int k = 0; k < n; k++) img.push_back($urandom);
        end
        kind = $urandom_range(0, 3);
        if (kind == 0) begin
            tgt = 1'($urandom_range(0, 1)); n = $urandom_range(2, 5);
            depth = tgt ? 1024 : 512;
            img.push_back({tgt, 5'd0, 10'(depth - n + 1), 16'(n)});
        end else if (kind == 1) begin
            img.push_back({1'b0, 5'(1 << $urandom_range(0, 4)), 10'd0, 16'd2});
        end else begin
            img.push_back({16'($urandom), 16'h0000});
        end
    endtask

    initial begin
        int base;
        do_reset(1'b1);

        build_happy();
        run_image("happy", 0);
        do_start();
        check("start_in_run_done", done, 1);
        check("start_in_run_ready", in_ready, 0);

        do_reset(1'b0);
        run_image("backpressure", 1);

        do_reset(1'b0);
        img = '{32'h01FE_0003, 32'h1, 32'h2, 32'h3, 32'h0};
        run_image("range_overflow", 0);

        do_reset(1'b0);
        img = '{32'h01FD_0003, 32'h11, 32'h22, 32'h33, 32'h0};
        run_image("range_exact_fit", 0);

        do_reset(1'b0);
        img = '{32'h0400_0001, 32'h5, 32'h0};
        run_image("reserved_bits", 0);

        // Abort after the second payload word, then reload from scratch.
        do_reset(1'b0);
        build_happy();
        base = obs_port.size();
        do_start();
        for (int i = 0; i < 3; i++) send_word(img[i], 0);
        arst_n = 1'b0;
        @(negedge clk);
        check("midrst_cpu_enable", cpu_enable, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_wen", {wen_ext, wen_ext_2}, 0);
        check("midrst_addr", addr_ext, 0);
        check("midrst_partial_writes", obs_port.size() - base, 2);
        $display("midload_reset: 2 payload words written before abort");
        arst_n = 1'b1;
        @(negedge clk);
        run_image("reload", 0);

        for (int t = 0; t < 10; t++) begin
            do_reset(1'b0);
            build_random();
            run_image($sformatf("random%0d", t), -1);
        end

`ifdef LOADER_VERIFY_EN
        do_reset(1'b0);
        corrupt_addr = 32'h4; corrupt_en = 1'b1;
        do_start();
        send_word(32'h0000_0003, 0);
        send_word(32'hCAFE_0001, 0);
        send_word(32'hCAFE_0002, 0);
        repeat (8) @(negedge clk);
        check("verify_error", error, 1);
        check("verify_err_code", err_code, 2'd3);
        check("verify_in_ready", in_ready, 0);
        check("verify_cpu_enable", cpu_enable, 0);
        $display("verify_corrupt: second word read back with bit 0 flipped");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
